pixel_event_sequencer: RTL and testbench

Upstream sequencer for the pixel controller. It generates the per-event PIX_STORE level, the opening and closing PIX_RESET pulses, the MEM_SET_EN/MEM_SET_CLR memory-advance handshake and TRG_DET. It counts completed events and raises EVT_NUM_END, so the controller inputs are no longer hand-driven. It sits between the DAQ register block (START/STOP/EVT_NUM/mode) and the pixel controller.

---
 rtl/pixel_event_sequencer_if.sv | 46 ++++
 rtl/pixel_event_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pixel_event_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_event_sequencer_if.sv
// Sequencer bus: DAQ run controls in, pixel-controller strobes and handshake out.
// TIMEOUT exists only when SEQ_TRG_TIMEOUT_EN is defined.
interface pixel_event_sequencer_if #(
  parameter int EVT_CNT_W = 8
);
  logic                 START;
  logic                 STOP;
  logic                 TRG_MODE_IN;
  logic                 TRG_IN;
  logic [EVT_CNT_W-1:0] EVT_NUM;
  logic                 PIX_RESET_BUSY;
  logic                 MEM_SET_DONE;
  logic                 LAST_MEM;
  logic                 PIX_RESET;
  logic                 PIX_STORE;
  logic                 MEM_SET_EN;
  logic                 MEM_SET_CLR;
  logic                 TRG_MODE;
  logic                 TRG_DET;
  logic                 EVT_NUM_END;
  logic                 BUSY;
  logic [EVT_CNT_W-1:0] EVT_CNT;
`ifdef SEQ_TRG_TIMEOUT_EN
  logic                 TIMEOUT;
`endif

  modport master (
`ifdef SEQ_TRG_TIMEOUT_EN
    output TIMEOUT,
`endif
    input  START, STOP, TRG_MODE_IN, TRG_IN, EVT_NUM,
    input  PIX_RESET_BUSY, MEM_SET_DONE, LAST_MEM,
    output PIX_RESET, PIX_STORE, MEM_SET_EN, MEM_SET_CLR,
    output TRG_MODE, TRG_DET, EVT_NUM_END, BUSY, EVT_CNT
  );

  modport slave (
`ifdef SEQ_TRG_TIMEOUT_EN
    input  TIMEOUT,
`endif
    output START, STOP, TRG_MODE_IN, TRG_IN, EVT_NUM,
    output PIX_RESET_BUSY, MEM_SET_DONE, LAST_MEM,
    input  PIX_RESET, PIX_STORE, MEM_SET_EN, MEM_SET_CLR,
    input  TRG_MODE, TRG_DET, EVT_NUM_END, BUSY, EVT_CNT
  );
endinterface

// File: rtl/pixel_event_sequencer.sv
// Event sequencer for the pixel controller: store window, reset pulses, memory-advance handshake.
// Define SEQ_TRG_TIMEOUT_EN to add the trigger-mode timeout and the sticky TIMEOUT flag.
module pixel_event_sequencer #(
  parameter int STORE_LEN   = 75,
  parameter int EVT_CNT_W   = 8,
  parameter int TRG_TIMEOUT = 1000
) (
  input logic                     CLK,
  input logic                     NRST_X,
  pixel_event_sequencer_if.master bus
);
  localparam int WIN_W = $clog2(STORE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_OPEN, S_INTEG, S_CLOSE, S_MEMSET, S_CLR, S_NEXT
  } state_t;

  state_t               state_q, state_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 trg_mode_q, trg_mode_d;
  logic [EVT_CNT_W-1:0] evt_num_q, evt_num_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic                 evt_end_q, evt_end_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 trg_pend_q, trg_pend_d;
  logic                 trg_hit_q, trg_hit_d;
  logic                 pix_store_q, pix_store_d;
  logic                 pix_reset_q, pix_reset_d;
  logic                 trg_det_q, trg_det_d;
  logic                 mem_set_en_q, mem_set_en_d;
  logic                 mem_set_clr_q, mem_set_clr_d;
  logic                 busy_q, busy_d;
  logic                 trg_seen;
  logic                 mem_ack;

`ifdef SEQ_TRG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TRG_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  // A trigger seen while the controller is busy stays pending until it can be honoured.
  assign trg_seen = bus.TRG_IN | trg_pend_q;
  // DONE counts only while MEM_SET_EN is visible to the controller.
  assign mem_ack  = mem_set_en_q & bus.MEM_SET_DONE;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    trg_mode_d  = trg_mode_q;
    evt_num_d   = evt_num_q;
    evt_cnt_d   = evt_cnt_q;
    evt_end_d   = evt_end_q;
    stop_pend_d = stop_pend_q;
    trg_pend_d  = 1'b0;
    trg_hit_d   = trg_hit_q;
`ifdef SEQ_TRG_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d     = S_ARM;
          trg_mode_d  = bus.TRG_MODE_IN;
          evt_num_d   = bus.EVT_NUM;
          evt_cnt_d   = '0;
          evt_end_d   = 1'b0;
          stop_pend_d = bus.STOP;
`ifdef SEQ_TRG_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      S_ARM:  state_d = S_OPEN;
      S_OPEN: begin
        state_d   = S_INTEG;
        win_d     = WIN_W'(1);
        trg_hit_d = 1'b0;
`ifdef SEQ_TRG_TIMEOUT_EN
        tmo_d     = TMO_W'(1);
`endif
      end
      S_INTEG: begin
        if (!trg_mode_q) begin
          if (win_q != WIN_W'(STORE_LEN)) win_d = win_q + 1'b1;
          else if (!bus.PIX_RESET_BUSY) state_d = S_CLOSE;
        end else if (trg_seen && !bus.PIX_RESET_BUSY) begin
          state_d   = S_CLOSE;
          trg_hit_d = 1'b1;
        end else begin
          trg_pend_d = trg_seen;
`ifdef SEQ_TRG_TIMEOUT_EN
          if (tmo_q != TMO_W'(TRG_TIMEOUT)) tmo_d = tmo_q + 1'b1;
          else if (!bus.PIX_RESET_BUSY) begin
            state_d   = S_CLOSE;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      S_CLOSE: state_d = S_MEMSET;
      S_MEMSET: begin
        if (mem_ack) begin
          if (evt_cnt_q != '1) evt_cnt_d = evt_cnt_q + 1'b1;
          state_d = bus.LAST_MEM ? S_CLR : S_NEXT;
        end
      end
      S_CLR:  state_d = S_NEXT;
      S_NEXT: begin
        if ((evt_num_q != '0) && (evt_cnt_q == evt_num_q)) begin
          evt_end_d = 1'b1;
          state_d   = S_IDLE;
        end else if (stop_pend_q || bus.STOP) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      if (state_d == S_IDLE) stop_pend_d = 1'b0;
      else if (bus.STOP)     stop_pend_d = 1'b1;
    end
  end

  // Output strobes are registered decodes of the current state, one edge behind it.
  always_comb begin
    pix_store_d   = (state_q == S_ARM) || (state_q == S_OPEN) ||
                    (state_q == S_INTEG) || (state_q == S_CLOSE);
    pix_reset_d   = (state_q == S_OPEN) || (state_q == S_CLOSE);
    trg_det_d     = (state_q == S_CLOSE) && trg_hit_q;
    mem_set_en_d  = (state_q == S_MEMSET) && !mem_ack;
    mem_set_clr_d = (state_q == S_CLR);
    busy_d        = (state_q != S_IDLE);
  end

  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      state_q       <= S_IDLE;
      win_q         <= '0;
      trg_mode_q    <= 1'b0;
      evt_num_q     <= '0;
      evt_cnt_q     <= '0;
      evt_end_q     <= 1'b0;
      stop_pend_q   <= 1'b0;
      trg_pend_q    <= 1'b0;
      trg_hit_q     <= 1'b0;
      pix_store_q   <= 1'b0;
      pix_reset_q   <= 1'b0;
      trg_det_q     <= 1'b0;
      mem_set_en_q  <= 1'b0;
      mem_set_clr_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      trg_mode_q    <= trg_mode_d;
      evt_num_q     <= evt_num_d;
      evt_cnt_q     <= evt_cnt_d;
      evt_end_q     <= evt_end_d;
      stop_pend_q   <= stop_pend_d;
      trg_pend_q    <= trg_pend_d;
      trg_hit_q     <= trg_hit_d;
      pix_store_q   <= pix_store_d;
      pix_reset_q   <= pix_reset_d;
      trg_det_q     <= trg_det_d;
      mem_set_en_q  <= mem_set_en_d;
      mem_set_clr_q <= mem_set_clr_d;
      busy_q        <= busy_d;
    end
  end

`ifdef SEQ_TRG_TIMEOUT_EN
  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.TIMEOUT = timeout_q;
`endif

  assign bus.PIX_RESET   = pix_reset_q;
  assign bus.PIX_STORE   = pix_store_q;
  assign bus.MEM_SET_EN  = mem_set_en_q;
  assign bus.MEM_SET_CLR = mem_set_clr_q;
  assign bus.TRG_MODE    = trg_mode_q;
  assign bus.TRG_DET     = trg_det_q;
  assign bus.EVT_NUM_END = evt_end_q;
  assign bus.BUSY        = busy_q;
  assign bus.EVT_CNT     = evt_cnt_q;
endmodule

// File: tb/tb_pixel_event_sequencer.sv
// Scoreboard bench for pixel_event_sequencer: expected strobe events (kind, cycle) are
// queued as runs are launched and matched against the strobes the DUT emits.
module tb_pixel_event_sequencer;
  localparam int L  = 75;
  localparam int CW = 8;

  localparam int K_PR  = 0;
  localparam int K_TD  = 1;
  localparam int K_CLR = 2;
  localparam int K_EN  = 3;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  logic CLK = 1'b0;
  logic NRST_X;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ack_dly = 3;
  int   last_at = 0;
  int   ack_num = 0;
  int   en_cnt = 0;
  evt_t sb[$];

  pixel_event_sequencer_if #(.EVT_CNT_W(CW)) bus ();

  pixel_event_sequencer #(
    .STORE_LEN  (L),
    .EVT_CNT_W  (CW),
    .TRG_TIMEOUT(1000)
  ) dut (
    .CLK   (CLK),
    .NRST_X(NRST_X),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pixel-controller model: acknowledges MEM_SET_EN after ack_dly visible cycles.
  always @(negedge CLK) begin
    bus.MEM_SET_DONE = 1'b0;
    bus.LAST_MEM     = 1'b0;
    if (!NRST_X || !bus.MEM_SET_EN) begin
      en_cnt = 0;
    end else begin
      en_cnt = en_cnt + 1;
      if (en_cnt == ack_dly) begin
        ack_num          = ack_num + 1;
        bus.MEM_SET_DONE = 1'b1;
        bus.LAST_MEM     = (ack_num == last_at);
      end
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int c);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int kind);
    evt_t e;
    if (sb.size() == 0) begin
      chk_val("unexpected_event_kind", kind, 255);
    end else begin
      e = sb.pop_front();
      chk_val("event_kind", kind, e.kind);
      chk_val($sformatf("event_cycle_k%0d", e.kind), cyc, e.cyc);
    end
  endtask

  task automatic mon_loop();
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.PIX_RESET)                  sb_check(K_PR);
      if (bus.TRG_DET)                    sb_check(K_TD);
      if (bus.MEM_SET_CLR)                sb_check(K_CLR);
      if (bus.MEM_SET_EN && !en_prev)     sb_check(K_EN);
      en_prev = bus.MEM_SET_EN;
    end
  endtask

  // One event starting (ARM) at edge s0 whose closing reset is observed at close_obs.
  task automatic push_evt(input int s0, input int close_obs, input bit trg, input bit clr,
                          output int nxt);
    int m;
    push_exp(K_PR, s0 + 2);
    push_exp(K_PR, close_obs);
    if (trg) push_exp(K_TD, close_obs);
    push_exp(K_EN, close_obs + 1);
    m = close_obs + 1 + ack_dly;
    if (clr) begin
      push_exp(K_CLR, m + 1);
      nxt = m + 2;
    end else begin
      nxt = m + 1;
    end
  endtask

  task automatic start_run(input bit mode, input int num, input bit stop, output int s0);
    bus.START       = 1'b1;
    bus.STOP        = stop;
    bus.TRG_MODE_IN = mode;
    bus.EVT_NUM     = CW'(num);
    s0              = cyc + 1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge CLK);
    while ((bus.BUSY || sb.size() != 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    chk_val({tag, "_busy"}, bus.BUSY, 0);
    chk_val({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk_val({tag, "_pix_store"}, bus.PIX_STORE, 0);
    chk_val({tag, "_pix_reset"}, bus.PIX_RESET, 0);
    chk_val({tag, "_mem_set_en"}, bus.MEM_SET_EN, 0);
    chk_val({tag, "_mem_set_clr"}, bus.MEM_SET_CLR, 0);
    chk_val({tag, "_trg_det"}, bus.TRG_DET, 0);
    chk_val({tag, "_busy"}, bus.BUSY, 0);
    chk_val({tag, "_evt_cnt"}, bus.EVT_CNT, 0);
    chk_val({tag, "_evt_num_end"}, bus.EVT_NUM_END, 0);
    chk_val({tag, "_trg_mode"}, bus.TRG_MODE, 0);
`ifdef SEQ_TRG_TIMEOUT_EN
    chk_val({tag, "_timeout"}, bus.TIMEOUT, 0);
`endif
  endtask

  initial begin
    int s0, s1, s2;
    NRST_X             = 1'b0;
    bus.START          = 1'b0;
    bus.STOP           = 1'b0;
    bus.TRG_MODE_IN    = 1'b0;
    bus.TRG_IN         = 1'b0;
    bus.EVT_NUM        = '0;
    bus.PIX_RESET_BUSY = 1'b0;

    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: cycle %0d reached without finishing, expected completion", cyc);
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(negedge CLK);
    chk_outs_zero("reset");
    NRST_X = 1'b1;
    @(negedge CLK);
    fork
      mon_loop();
    join_none

    // Timed run of two events, no memory wrap.
    ack_dly = 3;
    last_at = 0;
    start_run(1'b0, 2, 1'b0, s0);
    push_evt(s0, s0 + 3 + L, 1'b0, 1'b0, s1);
    push_evt(s1, s1 + 3 + L, 1'b0, 1'b0, s2);
    wait_idle("timed2");
    chk_val("timed2_evt_cnt", bus.EVT_CNT, 2);
    chk_val("timed2_evt_end", bus.EVT_NUM_END, 1);
    chk_val("timed2_trg_mode", bus.TRG_MODE, 0);
    chk_val("timed2_pix_store", bus.PIX_STORE, 0);

    // Four events with LAST_MEM on the third acknowledge.
    last_at = ack_num + 3;
    start_run(1'b0, 4, 1'b0, s0);
    push_evt(s0, s0 + 3 + L, 1'b0, 1'b0, s1);
    push_evt(s1, s1 + 3 + L, 1'b0, 1'b0, s2);
    push_evt(s2, s2 + 3 + L, 1'b0, 1'b1, s1);
    push_evt(s1, s1 + 3 + L, 1'b0, 1'b0, s2);
    wait_idle("wrap");
    chk_val("wrap_evt_cnt", bus.EVT_CNT, 4);
    chk_val("wrap_evt_end", bus.EVT_NUM_END, 1);

    // Trigger mode: direct trigger, ignored trigger in MEMSET, pending trigger under BUSY.
    ack_dly = 6;
    start_run(1'b1, 2, 1'b0, s0);
    push_evt(s0, s0 + 44, 1'b1, 1'b0, s1);
    push_evt(s1, s1 + 22, 1'b1, 1'b0, s2);
    wait_until(s0 + 42);
    bus.TRG_IN = 1'b1;
    @(negedge CLK);
    bus.TRG_IN = 1'b0;
    wait_until(s0 + 47);
    bus.TRG_IN = 1'b1;
    @(negedge CLK);
    bus.TRG_IN = 1'b0;
    wait_until(s1 + 5);
    bus.PIX_RESET_BUSY = 1'b1;
    wait_until(s1 + 10);
    bus.TRG_IN = 1'b1;
    @(negedge CLK);
    bus.TRG_IN = 1'b0;
    wait_until(s1 + 20);
    bus.PIX_RESET_BUSY = 1'b0;
    wait_idle("trig");
    chk_val("trig_evt_cnt", bus.EVT_CNT, 2);
    chk_val("trig_evt_end", bus.EVT_NUM_END, 1);
    chk_val("trig_trg_mode", bus.TRG_MODE, 1);

    // Timed window held open by PIX_RESET_BUSY past STORE_LEN.
    ack_dly = 3;
    bus.PIX_RESET_BUSY = 1'b1;
    start_run(1'b0, 1, 1'b0, s0);
    push_evt(s0, s0 + 94, 1'b0, 1'b0, s1);
    wait_until(s0 + 92);
    bus.PIX_RESET_BUSY = 1'b0;
    wait_idle("busyhold");
    chk_val("busyhold_evt_cnt", bus.EVT_CNT, 1);

    // Free-running run stopped mid-window: event completes, then IDLE.
    start_run(1'b0, 0, 1'b0, s0);
    push_evt(s0, s0 + 3 + L, 1'b0, 1'b0, s1);
    wait_until(s0 + 40);
    bus.STOP = 1'b1;
    @(negedge CLK);
    bus.STOP = 1'b0;
    wait_idle("stop");
    chk_val("stop_evt_cnt", bus.EVT_CNT, 1);
    chk_val("stop_evt_end", bus.EVT_NUM_END, 0);

    // START and STOP together: exactly one event.
    start_run(1'b0, 0, 1'b1, s0);
    push_evt(s0, s0 + 3 + L, 1'b0, 1'b0, s1);
    wait_idle("startstop");
    chk_val("startstop_evt_cnt", bus.EVT_CNT, 1);
    chk_val("startstop_evt_end", bus.EVT_NUM_END, 0);

    // Acknowledge in the cycle MEM_SET_EN rises; a mid-run START is ignored.
    ack_dly = 1;
    start_run(1'b0, 1, 1'b0, s0);
    push_evt(s0, s0 + 3 + L, 1'b0, 1'b0, s1);
    wait_until(s0 + 30);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_idle("fastack");
    chk_val("fastack_evt_cnt", bus.EVT_CNT, 1);
    chk_val("fastack_evt_end", bus.EVT_NUM_END, 1);

    // Asynchronous reset while waiting in MEMSET.
    ack_dly = 40;
    start_run(1'b0, 1, 1'b0, s0);
    push_exp(K_PR, s0 + 2);
    push_exp(K_PR, s0 + 3 + L);
    push_exp(K_EN, s0 + 4 + L);
    wait_until(s0 + 4 + L + 5);
    chk_val("memset_en_before_rst", bus.MEM_SET_EN, 1);
    #2 NRST_X = 1'b0;
    #1 chk_outs_zero("async_rst");
    @(negedge CLK);
    NRST_X = 1'b1;
    repeat (10) @(negedge CLK);
    chk_outs_zero("post_rst_idle");
    chk_val("post_rst_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
